gan_frame_streamer: RTL
=======================

Name: gan_frame_streamer

Overview:
- Sits directly downstream of the GAN wrapper.
- On each new generated frame, captures the flat 784-pixel Q8.8 frame plus both discriminator verdicts and scores into a local snapshot.
- Replays the snapshot as a framed 16-bit valid/ready word stream for a host link or debug FIFO.
- Decouples the GAN from slow consumers: the GAN can start its next run while the previous frame is still draining.

Parameters:
- PIXEL_COUNT, 784, number of 16-bit pixel words per frame.
- HEADER_WORD, 16'hA55A, constant first word of every packet.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_flat  in  16*PIXEL_COUNT  generated frame; pixel i occupies bits [(i+1)*16-1 -: 16].
- frame_valid  in  1  level; a rising edge marks a new frame.
- disc_fake_is_real  in  1  verdict on fake frame.
- disc_real_is_real  in  1  verdict on real frame.
- disc_fake_score  in  16  signed Q8.8 score.
- disc_real_score  in  16  signed Q8.8 score.
- out_data  out  16  stream word.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word.
- out_last  out  1  marks final word of packet.
- busy  out  1  packet in flight (state != IDLE).
- overflow  out  1  sticky flag: a frame was dropped.
- frame_count  out  16  accepted packets, wraps at 65535 -> 0.

Behaviour:
- Reset (async, rst_n low): state IDLE; out_data 0, out_valid 0, out_last 0, busy 0, overflow 0, frame_count 0; edge-detect register 0; snapshot contents don't-care.
- Reset mid-packet: stream aborts immediately; no partial-packet recovery.
- Edge detect: fv_q <= frame_valid each cycle; capture event = frame_valid & ~fv_q.
- Capture event in IDLE, cycle N:
  - snapshot frame, both flags and both scores;
  - clear running checksum; increment frame_count;
  - go to HDR; out_valid=1 with HEADER_WORD from cycle N+1.
- Capture event when not IDLE: frame dropped, snapshot untouched, overflow <= 1 (cleared only by reset).
- States and word order, one word per handshake (out_valid & out_ready):
  - HDR: HEADER_WORD.
  - FLAGS: {14'b0, disc_fake_is_real, disc_real_is_real}.
  - FSCORE: fake score.
  - RSCORE: real score.
  - PIX: pixel 0 .. PIXEL_COUNT-1, 10-bit index counter.
  - CSUM: checksum (only with the optional feature).
  - then IDLE.
- Handshake rules:
  - While out_valid & ~out_ready, out_data and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
  - Back-to-back handshakes sustain 1 word/clk.
- Checksum: 16-bit wrap-around sum of pixel words only, accumulated on each PIX handshake.
- Packet end: on the handshake of the last word, next state is IDLE and out_valid drops the following cycle.
- Simultaneous capture edge and last-word handshake: the edge is a drop (state not yet IDLE); overflow set.
- A capture edge is accepted from the first IDLE cycle onward.
- No combinational path from out_ready to out_valid.

Optional Feature:
- GAN_STREAM_CHECKSUM_EN defined:
  - CSUM word is appended after the last pixel and carries out_last.
  - Packet length is PIXEL_COUNT+5 words (789).
- Undefined:
  - CSUM state and checksum adder are removed; out_last is on pixel PIXEL_COUNT-1.
  - Packet length is PIXEL_COUNT+4 words (788).

Test Plan:
- Pixel i = i, fake score 16'h0180, real score 16'hFF00, flags 1/0, out_ready tied 1, rising edge on frame_valid:
  - words A55A, 0002, 0180, FF00, 0000..030F;
  - with checksum enabled, final word AEF8 with out_last;
  - total 789 cycles of out_valid; frame_count=1.
- Same frame, out_ready toggling pseudo-randomly: identical word sequence; out_data stable during every stall; no lost or duplicated words.
- Second frame_valid edge at word 100 of a packet: first packet completes unchanged; overflow=1; frame_count stays 1.
- Assert rst_n low at pixel 400: out_valid/busy/overflow/frame_count zero immediately; a later edge restarts a packet at A55A.
- frame_valid held high across packet completion: no new packet (edge only); a drop-to-low then high starts packet 2; frame_count=2.
- Checksum compiled out: out_last on pixel 783 (data 030F); packet is 788 words.

Source files
------------

// File: rtl/gan_stream_if.sv
// Framed 16-bit valid/ready word stream carrying GAN frame snapshots.
interface gan_stream_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/gan_frame_streamer.sv
// Snapshots each new GAN frame plus discriminator verdicts and replays it as a framed word stream.
// Optional trailing checksum word: define GAN_STREAM_CHECKSUM_EN.
module gan_frame_streamer #(
  parameter int          PIXEL_COUNT = 784,
  parameter logic [15:0] HEADER_WORD = 16'hA55A
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [16*PIXEL_COUNT-1:0] frame_flat,
  input  logic                      frame_valid,
  input  logic                      disc_fake_is_real,
  input  logic                      disc_real_is_real,
  input  logic [15:0]               disc_fake_score,
  input  logic [15:0]               disc_real_score,
  gan_stream_if.master              stream,
  output logic                      busy,
  output logic                      overflow,
  output logic [15:0]               frame_count
);

  typedef enum logic [2:0] {
    IDLE, HDR, FLAGS, FSCORE, RSCORE, PIX
`ifdef GAN_STREAM_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  typedef struct packed {
    logic        fake_is_real;
    logic        real_is_real;
    logic [15:0] fake_score;
    logic [15:0] real_score;
  } verdict_t;

  state_t state, state_nx;
  logic   fv_q;
  logic   cap, hs, pix_last;
  logic [9:0] pix_idx;

  logic [PIXEL_COUNT-1:0][15:0] snap_pix;
  verdict_t                     snap_vd;

  assign cap      = frame_valid & ~fv_q;
  assign hs       = stream.out_valid & stream.out_ready;
  assign pix_last = (pix_idx == 10'(PIXEL_COUNT-1));

  // Snapshot only loads on an accepted capture; contents are don't-care out of reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && cap) begin
      snap_pix <= frame_flat;
      snap_vd  <= '{fake_is_real: disc_fake_is_real, real_is_real: disc_real_is_real,
                    fake_score: disc_fake_score, real_score: disc_real_score};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fv_q        <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
      pix_idx     <= '0;
    end else begin
      state <= state_nx;
      fv_q  <= frame_valid;
      if (cap) begin
        if (state == IDLE) frame_count <= frame_count + 16'd1;
        else               overflow    <= 1'b1;
      end
      if (state == IDLE)           pix_idx <= '0;
      else if (state == PIX && hs) pix_idx <= pix_idx + 10'd1;
    end
  end

`ifdef GAN_STREAM_CHECKSUM_EN
  logic [15:0] csum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     csum <= '0;
    else if (state == IDLE && cap)  csum <= '0;
    else if (state == PIX && hs)    csum <= csum + snap_pix[pix_idx];
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (cap) state_nx = HDR;
      HDR:    if (hs)  state_nx = FLAGS;
      FLAGS:  if (hs)  state_nx = FSCORE;
      FSCORE: if (hs)  state_nx = RSCORE;
      RSCORE: if (hs)  state_nx = PIX;
`ifdef GAN_STREAM_CHECKSUM_EN
      PIX:    if (hs && pix_last) state_nx = CSUM;
      CSUM:   if (hs)  state_nx = IDLE;
`else
      PIX:    if (hs && pix_last) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only, so out_ready never reaches out_valid/out_data.
  always_comb begin
    stream.out_data = '0;
    stream.out_last = 1'b0;
    case (state)
      HDR:    stream.out_data = HEADER_WORD;
      FLAGS:  stream.out_data = {14'b0, snap_vd.fake_is_real, snap_vd.real_is_real};
      FSCORE: stream.out_data = snap_vd.fake_score;
      RSCORE: stream.out_data = snap_vd.real_score;
      PIX: begin
        stream.out_data = snap_pix[pix_idx];
`ifndef GAN_STREAM_CHECKSUM_EN
        stream.out_last = pix_last;
`endif
      end
`ifdef GAN_STREAM_CHECKSUM_EN
      CSUM: begin
        stream.out_data = csum;
        stream.out_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign stream.out_valid = (state != IDLE);
  assign busy             = (state != IDLE);

endmodule
